// File: rtl/instruction_fetch.sv
// instruction_fetch: RV32I fetch stage, 8-bit PC, single-outstanding imem reads.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect halts fetch and raises oMISALIGN.
module instruction_fetch #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            iCLK,
    input  logic            iRST_N,
    output logic            oIMEM_REQ,
    output logic [PC_W-1:0] oIMEM_ADDR,
    input  logic            iIMEM_VALID,
    input  logic [31:0]     iIMEM_RDATA,
    output logic [31:0]     oIR,
    output logic [PC_W-1:0] oPC,
    output logic            oIR_VALID,
    input  logic            iIR_READY,
    input  logic            iREDIRECT,
    input  logic [31:0]     iREDIRECT_PC,
    output logic            oMISALIGN
);

    localparam logic [1:0] S_FETCH = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_FLUSH = 2'd2;
    localparam logic [1:0] S_HALT  = 2'd3;

    localparam logic [31:0] NOP = 32'h0000_0013;

`ifdef FETCH_MISALIGN_TRAP_EN
    localparam bit TRAP_EN = 1'b1;
`else
    localparam bit TRAP_EN = 1'b0;
`endif

    logic [1:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] pend_q, pend_d;
    logic [PC_W-1:0] irpc_q, irpc_d;
    logic [31:0]     ir_q, ir_d;
    logic            mis_q, mis_d;

    logic [PC_W-1:0] tgt;
    logic [PC_W-1:0] pc_inc;
    logic            tgt_bad;
    logic            unused_bits;

    // Low target bits are dropped; with the trap enabled they flag a fault.
    assign tgt         = {iREDIRECT_PC[PC_W-1:2], 2'b00};
    assign tgt_bad     = TRAP_EN && (iREDIRECT_PC[1:0] != 2'b00);
    assign pc_inc      = pc_q + PC_W'(4);
    assign unused_bits = ^{iREDIRECT_PC[31:PC_W], iREDIRECT_PC[1:0]};

    // Request is suppressed while reset is held so the bus sees no fetch.
    assign oIMEM_REQ  = iRST_N && (state_q == S_FETCH || state_q == S_FLUSH);
    assign oIMEM_ADDR = {pc_q[PC_W-1:2], 2'b00};
    assign oIR        = ir_q;
    assign oPC        = irpc_q;
    assign oIR_VALID  = (state_q == S_HOLD);
    assign oMISALIGN  = mis_q;

    // Next-state and datapath selection for the fetch FSM.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        pend_d  = pend_q;
        irpc_d  = irpc_q;
        ir_d    = ir_q;
        mis_d   = mis_q;
        case (state_q)
            S_FETCH: begin
                if (iREDIRECT && tgt_bad) begin
                    mis_d   = 1'b1;
                    state_d = S_HALT;
                end else if (iREDIRECT) begin
                    if (iIMEM_VALID) begin
                        pc_d = tgt;
                    end else begin
                        pend_d  = tgt;
                        state_d = S_FLUSH;
                    end
                end else if (iIMEM_VALID) begin
                    ir_d    = iIMEM_RDATA;
                    irpc_d  = pc_q;
                    state_d = S_HOLD;
                end
            end
            S_FLUSH: begin
                if (iREDIRECT && tgt_bad) begin
                    mis_d   = 1'b1;
                    state_d = S_HALT;
                end else begin
                    if (iREDIRECT) begin
                        pend_d = tgt;
                    end
                    if (iIMEM_VALID) begin
                        pc_d    = iREDIRECT ? tgt : pend_q;
                        state_d = S_FETCH;
                    end
                end
            end
            S_HOLD: begin
                if (iREDIRECT && tgt_bad) begin
                    mis_d   = 1'b1;
                    state_d = S_HALT;
                end else if (iREDIRECT) begin
                    pc_d    = tgt;
                    state_d = S_FETCH;
                end else if (iIR_READY) begin
                    pc_d    = pc_inc;
                    state_d = S_FETCH;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state_q <= S_FETCH;
            pc_q    <= RESET_PC;
            pend_q  <= RESET_PC;
            irpc_q  <= RESET_PC;
            ir_q    <= NOP;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
            irpc_q  <= irpc_d;
            ir_q    <= ir_d;
            mis_q   <= mis_d;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed vector table, corner sequences,
// and a randomized run against a program-order reference model.
module tb_instruction_fetch;

    logic        iCLK;
    logic        iRST_N;
    logic        oIMEM_REQ;
    logic [7:0]  oIMEM_ADDR;
    logic        iIMEM_VALID;
    logic [31:0] iIMEM_RDATA;
    logic [31:0] oIR;
    logic [7:0]  oPC;
    logic        oIR_VALID;
    logic        iIR_READY;
    logic        iREDIRECT;
    logic [31:0] iREDIRECT_PC;
    logic        oMISALIGN;

    instruction_fetch #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .iCLK         (iCLK),
        .iRST_N       (iRST_N),
        .oIMEM_REQ    (oIMEM_REQ),
        .oIMEM_ADDR   (oIMEM_ADDR),
        .iIMEM_VALID  (iIMEM_VALID),
        .iIMEM_RDATA  (iIMEM_RDATA),
        .oIR          (oIR),
        .oPC          (oPC),
        .oIR_VALID    (oIR_VALID),
        .iIR_READY    (iIR_READY),
        .iREDIRECT    (iREDIRECT),
        .iREDIRECT_PC (iREDIRECT_PC),
        .oMISALIGN    (oMISALIGN)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    typedef struct {
        logic        rst_n;
        logic        vld;
        logic [31:0] rdata;
        logic        rdy;
        logic        redir;
        logic [31:0] rpc;
        logic        req;
        logic [7:0]  addr;
        logic        irv;
        logic [7:0]  pc;
        logic [31:0] ir;
    } vec_t;

    vec_t tbl[$];
    int   checks   = 0;
    int   failures = 0;

    function automatic void add(
        input logic rst_n, input logic vld, input logic [31:0] rdata,
        input logic rdy, input logic redir, input logic [31:0] rpc,
        input logic req, input logic [7:0] addr, input logic irv,
        input logic [7:0] pc, input logic [31:0] ir);
        vec_t v;
        v.rst_n = rst_n; v.vld = vld; v.rdata = rdata;
        v.rdy = rdy; v.redir = redir; v.rpc = rpc;
        v.req = req; v.addr = addr; v.irv = irv; v.pc = pc; v.ir = ir;
        tbl.push_back(v);
    endfunction

    task automatic chk(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] memw(input logic [7:0] a);
        return {a, ~a, 8'h5A, a ^ 8'h3C};
    endfunction

    task automatic drive(input logic vld, input logic [31:0] rdata,
                         input logic rdy, input logic redir,
                         input logic [31:0] rpc);
        iIMEM_VALID  = vld;
        iIMEM_RDATA  = rdata;
        iIR_READY    = rdy;
        iREDIRECT    = redir;
        iREDIRECT_PC = rpc;
    endtask

    logic [49:0] act_v, exp_v;
    logic [7:0]  exp_pc;
    logic [7:0]  prev_addr;
    logic        prev_req, prev_vld;
    int          cnt, lat, delivered;
    logic        rdy_r, redir_r;
    logic [31:0] rpc_r;

    initial begin
        iRST_N = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);

        add(0,0,32'h0,0,0,32'h0,          0,8'h00,0,8'h00,32'h0000_0013);
        add(1,1,32'hA0A0_0000,0,0,32'h0,  1,8'h00,0,8'h00,32'h0000_0013);
        add(1,0,32'h0,1,0,32'h0,          0,8'h00,1,8'h00,32'hA0A0_0000);
        add(1,1,32'hA4A4_0004,1,0,32'h0,  1,8'h04,0,8'h00,32'hA0A0_0000);
        add(1,0,32'h0,1,0,32'h0,          0,8'h04,1,8'h04,32'hA4A4_0004);
        add(1,0,32'h0,1,0,32'h0,          1,8'h08,0,8'h04,32'hA4A4_0004);
        add(1,0,32'h0,1,0,32'h0,          1,8'h08,0,8'h04,32'hA4A4_0004);
        add(1,0,32'h0,1,0,32'h0,          1,8'h08,0,8'h04,32'hA4A4_0004);
        add(1,1,32'hA8A8_0008,1,0,32'h0,  1,8'h08,0,8'h04,32'hA4A4_0004);
        add(1,0,32'h0,1,0,32'h0,          0,8'h08,1,8'h08,32'hA8A8_0008);
        add(1,1,32'hACAC_000C,1,0,32'h0,  1,8'h0C,0,8'h08,32'hA8A8_0008);
        add(1,0,32'h0,1,0,32'h0,          0,8'h0C,1,8'h0C,32'hACAC_000C);
        add(1,1,32'hB0B0_0010,0,0,32'h0,  1,8'h10,0,8'h0C,32'hACAC_000C);
        add(1,0,32'h0,0,1,32'h40,         0,8'h10,1,8'h10,32'hB0B0_0010);
        add(1,1,32'hC0C0_0040,0,0,32'h0,  1,8'h40,0,8'h10,32'hB0B0_0010);
        add(1,0,32'h0,1,0,32'h0,          0,8'h40,1,8'h40,32'hC0C0_0040);
        add(1,0,32'h0,0,1,32'h80,         1,8'h44,0,8'h40,32'hC0C0_0040);
        add(1,0,32'h0,0,0,32'h0,          1,8'h44,0,8'h40,32'hC0C0_0040);
        add(1,1,32'hDEAD_0044,0,0,32'h0,  1,8'h44,0,8'h40,32'hC0C0_0040);
        add(1,1,32'hE0E0_0080,0,0,32'h0,  1,8'h80,0,8'h40,32'hC0C0_0040);
        add(1,0,32'h0,1,1,32'hFC,         0,8'h80,1,8'h80,32'hE0E0_0080);
        add(1,1,32'hF0F0_00FC,0,0,32'h0,  1,8'hFC,0,8'h80,32'hE0E0_0080);
        add(1,0,32'h0,1,0,32'h0,          0,8'hFC,1,8'hFC,32'hF0F0_00FC);
        add(1,0,32'h0,0,0,32'h0,          1,8'h00,0,8'hFC,32'hF0F0_00FC);
        add(1,1,32'hBADB_AD00,0,1,32'h30, 1,8'h00,0,8'hFC,32'hF0F0_00FC);
        add(1,0,32'h0,0,0,32'h0,          1,8'h30,0,8'hFC,32'hF0F0_00FC);

        @(negedge iCLK);
        @(negedge iCLK);

        for (int i = 0; i < tbl.size(); i++) begin
            if (i != 0) @(negedge iCLK);
            iRST_N = tbl[i].rst_n;
            drive(tbl[i].vld, tbl[i].rdata, tbl[i].rdy,
                  tbl[i].redir, tbl[i].rpc);
            #1;
            act_v = {oIMEM_REQ, oIMEM_ADDR, oIR_VALID, oPC, oIR};
            exp_v = {tbl[i].req, tbl[i].addr, tbl[i].irv,
                     tbl[i].pc, tbl[i].ir};
            chk(act_v === exp_v, $sformatf("vec%0d", i),
                64'(act_v), 64'(exp_v));
        end

        // Misaligned redirect from S_FETCH at 0x30.
        @(negedge iCLK);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h42);
        @(negedge iCLK);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge iCLK);
            drive(1'b1, 32'h1234_5678, 1'b1, 1'b1, 32'h0);
            #1;
            chk({oIMEM_REQ, oIR_VALID, oMISALIGN} === 3'b001,
                $sformatf("halt%0d", k),
                64'({oIMEM_REQ, oIR_VALID, oMISALIGN}), 64'h1);
        end
`else
        drive(1'b1, 32'hDEAD_0030, 1'b0, 1'b0, 32'h0);
        #1;
        chk(oIMEM_REQ === 1'b1 && oIMEM_ADDR === 8'h30,
            "mis_flush_hold", 64'({oIMEM_REQ, oIMEM_ADDR}), 64'h130);
        @(negedge iCLK);
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        chk(oIMEM_REQ === 1'b1 && oIMEM_ADDR === 8'h40 && oMISALIGN === 1'b0,
            "mis_align_40",
            64'({oIMEM_REQ, oIMEM_ADDR, oMISALIGN}), 64'h280);
`endif

        // Reset while a flush is pending; late valid must be ignored.
        @(negedge iCLK);
        drive(1'b0, 32'h0, 1'b0, 1'b1, 32'h80);
        @(negedge iCLK);
        iRST_N = 1'b0;
        drive(1'b1, 32'h5555_5555, 1'b0, 1'b0, 32'h0);
        #1;
        chk(oIMEM_REQ === 1'b0, "rst_req", 64'(oIMEM_REQ), 64'h0);
        @(negedge iCLK);
        iRST_N = 1'b1;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        #1;
        act_v = {oIMEM_REQ, oIMEM_ADDR, oIR_VALID, oPC, oIR};
        exp_v = {1'b1, 8'h00, 1'b0, 8'h00, 32'h0000_0013};
        chk(act_v === exp_v && oMISALIGN === 1'b0, "rst_midflush",
            64'(act_v), 64'(exp_v));

        // Randomized run: delivered words must follow program order.
        exp_pc    = 8'h00;
        prev_req  = 1'b0;
        prev_vld  = 1'b0;
        prev_addr = 8'h00;
        cnt       = 0;
        lat       = $urandom_range(0, 3);
        delivered = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge iCLK);
            if (oIR_VALID) begin
                chk(oPC === exp_pc && oIR === memw(exp_pc), "rand_ir",
                    64'({oPC, oIR}), 64'({exp_pc, memw(exp_pc)}));
            end
            if (prev_req && !prev_vld) begin
                chk(oIMEM_REQ === 1'b1 && oIMEM_ADDR === prev_addr,
                    "rand_addr_hold", 64'({oIMEM_REQ, oIMEM_ADDR}),
                    64'({1'b1, prev_addr}));
            end
            if (oIMEM_REQ) begin
                chk(oIMEM_ADDR[1:0] === 2'b00, "rand_align",
                    64'(oIMEM_ADDR), 64'(oIMEM_ADDR & 8'hFC));
            end
            chk(oMISALIGN === 1'b0, "rand_mis", 64'(oMISALIGN), 64'h0);

            rdy_r   = ($urandom_range(0, 1) == 1);
            redir_r = ($urandom_range(0, 9) == 0);
            rpc_r   = $urandom;
`ifdef FETCH_MISALIGN_TRAP_EN
            rpc_r[1:0] = 2'b00;
`endif
            if (oIMEM_REQ) begin
                if (cnt >= lat) begin
                    drive(1'b1, memw(oIMEM_ADDR), rdy_r, redir_r, rpc_r);
                    cnt = 0;
                    lat = $urandom_range(0, 3);
                end else begin
                    drive(1'b0, $urandom, rdy_r, redir_r, rpc_r);
                    cnt++;
                end
            end else begin
                drive(1'b0, $urandom, rdy_r, redir_r, rpc_r);
                cnt = 0;
            end
            prev_req  = oIMEM_REQ;
            prev_vld  = iIMEM_VALID;
            prev_addr = oIMEM_ADDR;
            if (oIR_VALID && rdy_r) delivered++;
            if (redir_r) exp_pc = rpc_r[7:0] & 8'hFC;
            else if (oIR_VALID && rdy_r) exp_pc = exp_pc + 8'd4;
        end
        chk(delivered >= 100, "rand_progress", 64'(delivered), 64'd100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
